// File: rtl/seq_detect_pkg.sv
// Shared definitions for the run-time configurable sequence detector:
// state encoding, minimum legal pattern length and a width helper.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FILL = 2'b01,
        RUN  = 2'b10
    } state_e;

    localparam int MIN_LEN = 2;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/seq_hist_shift.sv
// History shift register (newest bit in hist[0]) with a fill counter that
// saturates at MAX_W. Priority: clear, then flush, then shift.
module seq_hist_shift
    import seq_detect_pkg::*;
#(
    parameter int MAX_W  = 8,
    parameter int FILL_W = clog2(MAX_W + 1)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              flush,
    input  logic              shift,
    input  logic              din,
    output logic [MAX_W-1:0]  hist,
    output logic [FILL_W-1:0] fill
);

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_W);

    logic [MAX_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (flush) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift) begin
            hist_d = {hist_q[MAX_W-2:0], din};
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign hist = hist_q;
    assign fill = fill_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial sequence detector with run-time pattern/length/overlap config.
// Optional saturating match counter on port match_cnt: SEQ_DETECT_MATCH_CNT_EN.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int MAX_W = 8,
    parameter int CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         clear,
    input  logic                         din_valid,
    input  logic                         din,
    input  logic                         cfg_load,
    input  logic [MAX_W-1:0]             cfg_pattern,
    input  logic [clog2(MAX_W+1)-1:0]    cfg_len,
    input  logic                         cfg_overlap,
    output logic                         dout,
    output logic [1:0]                   present_state,
    output logic                         cfg_err
`ifdef SEQ_DETECT_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]             match_cnt
`endif
);

    localparam int LEN_W = clog2(MAX_W + 1);

    logic [MAX_W-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             overlap_q, overlap_d;
    state_e           state_q, state_d;
    logic             dout_q, dout_d;
    logic             cfg_err_q, cfg_err_d;

    logic [MAX_W-1:0] hist;
    logic [LEN_W-1:0] fill;
    logic             load_ok, sample, enough, match, flush;
    logic [MAX_W:0]   mask_ext;
    logic [MAX_W-1:0] mask, window;

    assign load_ok = cfg_load && (cfg_len >= LEN_W'(MIN_LEN)) && (cfg_len <= LEN_W'(MAX_W));
    // A load in the same cycle always wins over the data bit, even if rejected.
    assign sample  = din_valid && !cfg_load && (state_q != IDLE);
    assign enough  = ({1'b0, fill} + 1'b1) >= {1'b0, len_q};

    assign mask_ext = ({{MAX_W{1'b0}}, 1'b1} << len_q) - 1'b1;
    assign mask     = mask_ext[MAX_W-1:0];
    assign window   = {hist[MAX_W-2:0], din};
    assign match    = sample && enough && ((window & mask) == (pattern_q & mask));
    assign flush    = load_ok || (match && !overlap_q);

    seq_hist_shift #(
        .MAX_W  (MAX_W),
        .FILL_W (LEN_W)
    ) u_hist (
        .clk   (clk),
        .clear (clear),
        .flush (flush),
        .shift (sample),
        .din   (din),
        .hist  (hist),
        .fill  (fill)
    );

    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        state_d   = state_q;
        cfg_err_d = cfg_err_q;
        dout_d    = match;
        if (cfg_load) begin
            if (load_ok) begin
                pattern_d = cfg_pattern;
                len_d     = cfg_len;
                overlap_d = cfg_overlap;
                state_d   = FILL;
                cfg_err_d = 1'b0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (sample) begin
            if (match && !overlap_q) begin
                state_d = FILL;
            end else if (enough) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            state_q   <= IDLE;
            dout_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            state_q   <= state_d;
            dout_q    <= dout_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign dout          = dout_q;
    assign present_state = state_q;
    assign cfg_err       = cfg_err_q;

`ifdef SEQ_DETECT_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_ok) begin
            cnt_d = '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`endif

endmodule
